diff_pair_rx: RTL



---
 rtl/diff_pair_rx_pkg.sv | 35 +++
 rtl/diff_pair_sync.sv | 37 +++
 rtl/diff_pair_rx.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/diff_pair_rx_pkg.sv
// ---------------------------------------------------------------------------
// diff_pair_rx_pkg
// Shared types and default constants for the differential-pair receiver.
//   state_t : receiver FSM states (acquire, locked low, locked high, fault)
//   cls_t   : per-sample classification of the synchronised pad pair
//   DEF_*   : default parameter values used by diff_pair_rx
//   max_int : small helper for sizing the run counter
// ---------------------------------------------------------------------------
package diff_pair_rx_pkg;

    typedef enum logic [1:0] {
        S_ACQ   = 2'd0,
        S_LO    = 2'd1,
        S_HI    = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        CLS_LOW  = 2'd0,
        CLS_HIGH = 2'd1,
        CLS_INV  = 2'd2
    } cls_t;

    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_STABLE_CYCLES = 4;
    localparam int DEF_FAULT_CYCLES  = 8;
    localparam int DEF_CNT_W         = 8;

    // Larger of two integers; the run counter only needs to count up to the
    // longer of the two qualification windows.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/diff_pair_sync.sv
// ---------------------------------------------------------------------------
// diff_pair_sync
// Multi-flop synchroniser for one leg of the differential pad pair.
// Parameters:
//   STAGES    : number of flops in the chain (>= 2)
//   RESET_VAL : value every flop takes during reset
// Ports:
//   clk   : receiver clock
//   rst_n : synchronous active-low reset
//   d     : asynchronous pad input
//   q     : synchronised output (last flop of the chain)
// ---------------------------------------------------------------------------
module diff_pair_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Shift the pad value through the chain; the first flop may go
    // metastable, later flops give it time to resolve before use.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chain <= {STAGES{RESET_VAL}};
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/diff_pair_rx.sv
// ---------------------------------------------------------------------------
// diff_pair_rx
// Differential-pair input receiver. Synchronises the true/complement pad
// legs, classifies each sample as HIGH/LOW/INVALID, deglitches level changes
// and declares a line fault on a sustained invalid pair.
// Optional feature macro: DIFF_PAIR_RX_ERRCNT_EN adds a saturating count of
// fault entries (err_cnt) with a synchronous clear (err_clr). Without it the
// err_cnt port does not exist and err_clr has no effect.
// Ports:
//   clk     : single clock
//   rst_n   : synchronous active-low reset
//   pad_t   : true leg (asynchronous)
//   pad_c   : complement leg (asynchronous)
//   err_clr : synchronous clear of err_cnt
//   dout    : deglitched received level
//   rise    : one-cycle pulse on a locked 0->1 change of dout
//   fall    : one-cycle pulse on a locked 1->0 change of dout
//   valid   : pair locked (S_LO or S_HI)
//   fault   : sustained invalid pair (S_FAULT)
//   err_cnt : saturating fault-entry count (macro builds only)
// ---------------------------------------------------------------------------
module diff_pair_rx
    import diff_pair_rx_pkg::*;
#(
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int FAULT_CYCLES  = DEF_FAULT_CYCLES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pad_t,
    input  logic             pad_c,
    input  logic             err_clr,
    output logic             dout,
    output logic             rise,
    output logic             fall,
    output logic             valid,
    output logic             fault
`ifdef DIFF_PAIR_RX_ERRCNT_EN
    ,
    output logic [CNT_W-1:0] err_cnt
`endif
);

    localparam int RUN_MAX = max_int(STABLE_CYCLES, FAULT_CYCLES);
    localparam int RUN_W   = $clog2(RUN_MAX + 1);

    localparam logic [RUN_W-1:0] RUN_SAT    = RUN_W'(RUN_MAX);
    localparam logic [RUN_W-1:0] STABLE_CNT = RUN_W'(STABLE_CYCLES);
    localparam logic [RUN_W-1:0] FAULT_CNT  = RUN_W'(FAULT_CYCLES);

    logic             sync_t;
    logic             sync_c;
    cls_t             cls;
    cls_t             run_cls;
    logic [RUN_W-1:0] run_cnt;

    state_t           state;
    state_t           state_next;
    logic             dout_next;
    logic             rise_next;
    logic             fall_next;
    logic             valid_next;
    logic             fault_next;

    logic             hi_ok;
    logic             lo_ok;
    logic             inv_ok;

    // Both legs clear to the (0,1) LOW pattern so the pair looks like a
    // legal LOW level straight out of reset.
    diff_pair_sync #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b0)
    ) u_sync_t (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pad_t),
        .q     (sync_t)
    );

    diff_pair_sync #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_sync_c (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pad_c),
        .q     (sync_c)
    );

    // Classify the synchronised pair. Equal legs mean the far-end driver is
    // off, contended or the line is broken, so they are treated as invalid.
    always_comb begin
        cls = CLS_INV;
        case ({sync_t, sync_c})
            2'b10:   cls = CLS_HIGH;
            2'b01:   cls = CLS_LOW;
            default: cls = CLS_INV;
        endcase
    end

    // Run-length tracker: remembers the class of the current run and how long
    // it has lasted. It saturates so a long steady line never wraps and
    // retriggers a transition.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_cls <= CLS_LOW;
            run_cnt <= '0;
        end else begin
            run_cls <= cls;
            if (cls != run_cls) begin
                run_cnt <= RUN_W'(1);
            end else if (run_cnt != RUN_SAT) begin
                run_cnt <= run_cnt + RUN_W'(1);
            end
        end
    end

    assign hi_ok  = (run_cls == CLS_HIGH) && (run_cnt >= STABLE_CNT);
    assign lo_ok  = (run_cls == CLS_LOW)  && (run_cnt >= STABLE_CNT);
    assign inv_ok = (run_cls == CLS_INV)  && (run_cnt >= FAULT_CNT);

    // State register; dout and the status flags are registered alongside the
    // state so every output comes straight from a flop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_ACQ;
            dout  <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
            valid <= 1'b0;
            fault <= 1'b0;
        end else begin
            state <= state_next;
            dout  <= dout_next;
            rise  <= rise_next;
            fall  <= fall_next;
            valid <= valid_next;
            fault <= fault_next;
        end
    end

    // Next-state logic. Edge pulses are only produced when moving between the
    // two locked states; acquiring a level from S_ACQ or recovering from
    // S_FAULT updates dout silently because there was no trusted previous
    // level to have an edge from.
    always_comb begin
        state_next = state;
        dout_next  = dout;
        rise_next  = 1'b0;
        fall_next  = 1'b0;

        case (state)
            S_ACQ: begin
                if (hi_ok) begin
                    state_next = S_HI;
                    dout_next  = 1'b1;
                end else if (lo_ok) begin
                    state_next = S_LO;
                    dout_next  = 1'b0;
                end else if (inv_ok) begin
                    state_next = S_FAULT;
                end
            end
            S_LO: begin
                if (hi_ok) begin
                    state_next = S_HI;
                    dout_next  = 1'b1;
                    rise_next  = 1'b1;
                end else if (inv_ok) begin
                    state_next = S_FAULT;
                end
            end
            S_HI: begin
                if (lo_ok) begin
                    state_next = S_LO;
                    dout_next  = 1'b0;
                    fall_next  = 1'b1;
                end else if (inv_ok) begin
                    state_next = S_FAULT;
                end
            end
            S_FAULT: begin
                if (hi_ok) begin
                    state_next = S_HI;
                    dout_next  = 1'b1;
                end else if (lo_ok) begin
                    state_next = S_LO;
                    dout_next  = 1'b0;
                end
            end
            default: begin
                state_next = S_ACQ;
            end
        endcase

        valid_next = (state_next == S_LO) || (state_next == S_HI);
        fault_next = (state_next == S_FAULT);
    end

`ifdef DIFF_PAIR_RX_ERRCNT_EN
    logic fault_entry;

    assign fault_entry = (state_next == S_FAULT) && (state != S_FAULT);

    // Fault-entry counter. A clear that coincides with a new entry keeps
    // that entry, so the count restarts at 1 rather than losing the event.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (err_clr && fault_entry) begin
            err_cnt <= CNT_W'(1);
        end else if (err_clr) begin
            err_cnt <= '0;
        end else if (fault_entry && (err_cnt != {CNT_W{1'b1}})) begin
            err_cnt <= err_cnt + CNT_W'(1);
        end
    end
`else
    logic unused_err_clr;

    assign unused_err_clr = err_clr;
`endif

endmodule
